// File: rtl/joy_pkg.sv
// Shared definitions for the multi-channel joystick mapper: protocol codes,
// I/O port decode constants and the per-channel config reset values.
package joy_pkg;

    typedef enum logic [2:0] {
        PROTO_DIS  = 3'd0,
        PROTO_KEMP = 3'd1,
        PROTO_SP1  = 3'd2,
        PROTO_SP2  = 3'd3,
        PROTO_CURS = 3'd4,
        PROTO_FULL = 3'd5
    } proto_e;

    localparam logic [7:0] KEMPSTON_PORT = 8'h1F;
    localparam logic [7:0] FULLER_PORT   = 8'h7F;

    // Address lines that select the Sinclair keyboard half-rows
    localparam int unsigned SP1_ABIT = 12;
    localparam int unsigned SP2_ABIT = 11;

    // Bit positions inside one channel's accepted button vector
    localparam int unsigned BTN_R  = 0;
    localparam int unsigned BTN_L  = 1;
    localparam int unsigned BTN_D  = 2;
    localparam int unsigned BTN_U  = 3;
    localparam int unsigned BTN_F1 = 4;
    localparam int unsigned BTN_F2 = 5;
    localparam int unsigned BTN_F3 = 6;
    localparam int unsigned BTN_MAX = 7;

    // Channel 0 boots as Kempston, channel 1 as Sinclair P1, the rest disabled
    function automatic logic [7:0] joyconf_reset(input int unsigned k);
        case (k)
            0:       return 8'h01;
            1:       return 8'h02;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/joy_debounce.sv
// One joystick input bit: 2-flop synchroniser, stability counter and the
// accepted (pressed = 1) state. Pin-to-accepted latency is DEBOUNCE_CYCLES+3.
module joy_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic pressed
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          prev;
    logic [CW-1:0] cnt;

    // Synchronise the inverted pin, restart the counter on any change and
    // accept the synced value once it has been stable for the full window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            prev    <= 1'b0;
            cnt     <= '0;
            pressed <= 1'b0;
        end else begin
            sync1 <= ~pin;
            sync2 <= sync1;
            prev  <= sync2;
            if (sync2 != prev) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else begin
                pressed <= sync2;
            end
        end
    end

endmodule

// File: rtl/joystick_mapper_multi.sv
// Multi-channel joystick front end: debounces every pad input, applies
// per-channel autofire to fire1 and maps channels onto Kempston, Fuller,
// Sinclair P1/P2 and Cursor protocols under ZXUNO config registers.
module joystick_mapper_multi
    import joy_pkg::*;
#(
    parameter int unsigned NCHAN           = 2,
    parameter int unsigned NBUTTONS        = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter logic [7:0]  JOYCONF_BASE    = 8'h06
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   a,
    input  logic                          iorq_n,
    input  logic                          rd_n,
    input  logic [7:0]                    din,
    output logic [7:0]                    dout,
    output logic                          oe_n,
    input  logic [7:0]                    zxuno_addr,
    input  logic                          zxuno_regrd,
    input  logic                          zxuno_regwr,
    input  logic [NCHAN*(4+NBUTTONS)-1:0] joy_in,
    input  logic [4:0]                    kbdcol_in,
    output logic [4:0]                    kbdcol_out,
    input  logic                          vertical_retrace_int_n
);
    localparam int unsigned W = 4 + NBUTTONS;

    logic [NCHAN*W-1:0] acc;
    logic [6:0]         btn [NCHAN];

    logic [7:0]       joyconf [NCHAN];
    logic [NCHAN-1:0] wr_hit;
    logic [NCHAN-1:0] rd_hit;

    logic             vrt_s1, vrt_s2, vrt_s3;
    logic             frame_edge;
    logic [3:0]       af_cnt [NCHAN];
    logic [3:0]       af_hp  [NCHAN];
    logic [NCHAN-1:0] af_wrap;
    logic [NCHAN-1:0] af_phase;
    logic [NCHAN-1:0] fire1_eff;

    logic [7:0] kemp_byte;
    logic [7:0] fuller_byte;
    logic [4:0] row12_mask;
    logic [4:0] row11_mask;
    logic [7:0] zx_data;
    logic       io_rd;

    logic unused_addr;
    assign unused_addr = ^{a[15:13], a[10:8]};

    for (genvar g = 0; g < NCHAN * W; g++) begin : g_db
        joy_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .rst     (rst),
            .pin     (joy_in[g]),
            .pressed (acc[g])
        );
    end

    // Missing fire buttons are zero-extended so every channel has 7 bits
    for (genvar c = 0; c < NCHAN; c++) begin : g_btn
        assign btn[c] = 7'(acc[c*W +: W]);
    end

    // ZXUNO address decode per channel
    always_comb begin
        wr_hit = '0;
        rd_hit = '0;
        for (int unsigned k = 0; k < NCHAN; k++) begin
            wr_hit[k] = zxuno_regwr && (zxuno_addr == JOYCONF_BASE + 8'(k));
            rd_hit[k] = zxuno_regrd && (zxuno_addr == JOYCONF_BASE + 8'(k));
        end
    end

    // Config registers load on a matching ZXUNO write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NCHAN; k++) begin
                joyconf[k] <= joyconf_reset(k);
            end
        end else begin
            for (int unsigned k = 0; k < NCHAN; k++) begin
                if (wr_hit[k]) begin
                    joyconf[k] <= din;
                end
            end
        end
    end

    // Synchronise the frame interrupt and keep one delayed copy for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vrt_s1 <= 1'b0;
            vrt_s2 <= 1'b0;
            vrt_s3 <= 1'b0;
        end else begin
            vrt_s1 <= vertical_retrace_int_n;
            vrt_s2 <= vrt_s1;
            vrt_s3 <= vrt_s2;
        end
    end

    assign frame_edge = vrt_s2 & ~vrt_s3;

    // Effective half-period, counter wrap condition and gated fire1
    always_comb begin
        for (int unsigned k = 0; k < NCHAN; k++) begin
            af_hp[k]     = (joyconf[k][7:4] == 4'd0) ? 4'd1 : joyconf[k][7:4];
            af_wrap[k]   = ({1'b0, af_cnt[k]} + 5'd1) >= {1'b0, af_hp[k]};
            fire1_eff[k] = btn[k][BTN_F1] & (joyconf[k][3] ? af_phase[k] : 1'b1);
        end
    end

    // Autofire frame counters; a config write restarts the channel in phase 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NCHAN; k++) begin
                af_cnt[k] <= '0;
            end
            af_phase <= '1;
        end else begin
            for (int unsigned k = 0; k < NCHAN; k++) begin
                if (wr_hit[k]) begin
                    af_cnt[k]   <= '0;
                    af_phase[k] <= 1'b1;
                end else if (frame_edge && joyconf[k][3]) begin
                    if (af_wrap[k]) begin
                        af_cnt[k]   <= '0;
                        af_phase[k] <= ~af_phase[k];
                    end else begin
                        af_cnt[k] <= af_cnt[k] + 4'd1;
                    end
                end
            end
        end
    end

    // Merge all channels per protocol: OR for Kempston, AND for active-low maps
    always_comb begin
        kemp_byte   = '0;
        fuller_byte = '1;
        row12_mask  = '1;
        row11_mask  = '1;
        for (int unsigned k = 0; k < NCHAN; k++) begin
            case (proto_e'(joyconf[k][2:0]))
                PROTO_KEMP: kemp_byte = kemp_byte | {1'b0, btn[k][BTN_F3], btn[k][BTN_F2],
                                                     fire1_eff[k], btn[k][BTN_U], btn[k][BTN_D],
                                                     btn[k][BTN_L], btn[k][BTN_R]};
                PROTO_FULL: fuller_byte = fuller_byte & {~fire1_eff[k], 3'b111, ~btn[k][BTN_R],
                                                         ~btn[k][BTN_L], ~btn[k][BTN_D], ~btn[k][BTN_U]};
                PROTO_SP1:  row12_mask = row12_mask & {~btn[k][BTN_L], ~btn[k][BTN_R], ~btn[k][BTN_D],
                                                       ~btn[k][BTN_U], ~fire1_eff[k]};
                PROTO_SP2:  row11_mask = row11_mask & {~fire1_eff[k], ~btn[k][BTN_U], ~btn[k][BTN_D],
                                                       ~btn[k][BTN_R], ~btn[k][BTN_L]};
                PROTO_CURS: begin
                    row12_mask = row12_mask & {~btn[k][BTN_D], ~btn[k][BTN_U], ~btn[k][BTN_R],
                                               1'b1, ~fire1_eff[k]};
                    row11_mask = row11_mask & {~btn[k][BTN_L], 4'b1111};
                end
                default: ;
            endcase
        end
    end

    // Config read-back data for the matching channel
    always_comb begin
        zx_data = '1;
        for (int unsigned k = 0; k < NCHAN; k++) begin
            if (rd_hit[k]) begin
                zx_data = joyconf[k];
            end
        end
    end

    assign io_rd = !iorq_n && !rd_n;

    // Read data mux in priority order: ZXUNO config, Kempston, Fuller
    always_comb begin
        dout = 8'hFF;
        oe_n = 1'b1;
        if (|rd_hit) begin
            dout = zx_data;
            oe_n = 1'b0;
        end else if (io_rd && a[7:0] == KEMPSTON_PORT) begin
            dout = kemp_byte;
            oe_n = 1'b0;
        end else if (io_rd && a[7:0] == FULLER_PORT) begin
            dout = fuller_byte;
            oe_n = 1'b0;
        end
    end

    // Keyboard column path: joystick maps applied to the addressed half-rows
    always_comb begin
        kbdcol_out = kbdcol_in;
        if (!a[0]) begin
            if (!a[SP1_ABIT]) begin
                kbdcol_out = kbdcol_out & row12_mask;
            end
            if (!a[SP2_ABIT]) begin
                kbdcol_out = kbdcol_out & row11_mask;
            end
        end
    end

endmodule

// File: tb/tb_joystick_mapper_multi.sv
// Self-checking bench for joystick_mapper_multi with a fast debounce window.
module tb_joystick_mapper_multi;
    localparam int unsigned NCHAN = 2;
    localparam int unsigned NB    = 3;
    localparam int unsigned DC    = 4;
    localparam int unsigned W     = 4 + NB;
    localparam logic [7:0]  BASE  = 8'h06;

    logic                 clk;
    logic                 rst;
    logic [15:0]          a;
    logic                 iorq_n;
    logic                 rd_n;
    logic [7:0]           din;
    logic [7:0]           dout;
    logic                 oe_n;
    logic [7:0]           zxuno_addr;
    logic                 zxuno_regrd;
    logic                 zxuno_regwr;
    logic [NCHAN*W-1:0]   joy_in;
    logic [4:0]           kbdcol_in;
    logic [4:0]           kbdcol_out;
    logic                 vrt;

    int checks;
    int failures;

    logic [7:0]  m_conf   [NCHAN];
    int unsigned m_frames [NCHAN];

    typedef struct {
        string       name;
        logic [15:0] a;
        logic        iorq_n;
        logic        rd_n;
        logic [7:0]  zaddr;
        logic        zrd;
        logic [4:0]  kin;
        logic [7:0]  edout;
        logic        eoe;
        logic [4:0]  ekbd;
    } vec_t;

    vec_t tbl [10];

    joystick_mapper_multi #(
        .NCHAN           (NCHAN),
        .NBUTTONS        (NB),
        .DEBOUNCE_CYCLES (DC),
        .JOYCONF_BASE    (BASE)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .a                      (a),
        .iorq_n                 (iorq_n),
        .rd_n                   (rd_n),
        .din                    (din),
        .dout                   (dout),
        .oe_n                   (oe_n),
        .zxuno_addr             (zxuno_addr),
        .zxuno_regrd            (zxuno_regrd),
        .zxuno_regwr            (zxuno_regwr),
        .joy_in                 (joy_in),
        .kbdcol_in              (kbdcol_in),
        .kbdcol_out             (kbdcol_out),
        .vertical_retrace_int_n (vrt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic io_read(input logic [15:0] addr, output logic [7:0] d,
                           output logic o, output logic [4:0] k);
        a = addr;
        iorq_n = 1'b0;
        rd_n = 1'b0;
        #1;
        d = dout;
        o = oe_n;
        k = kbdcol_out;
        iorq_n = 1'b1;
        rd_n = 1'b1;
        a = 16'hFFFF;
    endtask

    task automatic zx_read(input logic [7:0] addr, output logic [7:0] d, output logic o);
        zxuno_addr = addr;
        zxuno_regrd = 1'b1;
        #1;
        d = dout;
        o = oe_n;
        zxuno_regrd = 1'b0;
    endtask

    task automatic zx_write(input logic [7:0] addr, input logic [7:0] data);
        zxuno_addr = addr;
        din = data;
        zxuno_regwr = 1'b1;
        step(1);
        zxuno_regwr = 1'b0;
        if (addr >= BASE && addr < BASE + 8'(NCHAN)) begin
            m_conf[addr - BASE] = data;
            m_frames[addr - BASE] = 0;
        end
    endtask

    task automatic frame();
        vrt = 1'b0;
        step(3);
        vrt = 1'b1;
        step(4);
        for (int ch = 0; ch < NCHAN; ch++) begin
            if (m_conf[ch][3]) m_frames[ch]++;
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NCHAN; ch++) begin
            m_conf[ch] = (ch == 0) ? 8'h01 : (ch == 1) ? 8'h02 : 8'h00;
            m_frames[ch] = 0;
        end
    endtask

    // Pressed buttons of a channel (1 = pressed), once inputs have settled
    function automatic logic [6:0] pr(input int ch);
        logic [W-1:0] raw;
        raw = joy_in[ch*W +: W];
        return 7'(~raw);
    endfunction

    // Autofire: phase flips every hp counted frames since the last write
    function automatic logic f1(input int ch);
        int unsigned hp;
        logic        ph;
        hp = (m_conf[ch][7:4] == 0) ? 1 : int'(m_conf[ch][7:4]);
        ph = ((m_frames[ch] / hp) % 2) == 0;
        return pr(ch)[4] & (m_conf[ch][3] ? ph : 1'b1);
    endfunction

    function automatic logic [7:0] exp_kemp();
        logic [7:0] v;
        logic [6:0] p;
        v = 8'h00;
        for (int ch = 0; ch < NCHAN; ch++) begin
            p = pr(ch);
            if (m_conf[ch][2:0] == 3'd1) v |= {1'b0, p[6], p[5], f1(ch), p[3:0]};
        end
        return v;
    endfunction

    function automatic logic [7:0] exp_fuller();
        logic [7:0] v;
        logic [6:0] p;
        v = 8'hFF;
        for (int ch = 0; ch < NCHAN; ch++) begin
            p = pr(ch);
            if (m_conf[ch][2:0] == 3'd5) v &= {~f1(ch), 3'b111, ~p[0], ~p[1], ~p[2], ~p[3]};
        end
        return v;
    endfunction

    function automatic logic [4:0] exp_kbd(input logic [15:0] addr, input logic [4:0] kin);
        logic [4:0] k;
        logic [6:0] p;
        logic [2:0] pc;
        k = kin;
        if (!addr[0]) begin
            for (int ch = 0; ch < NCHAN; ch++) begin
                p = pr(ch);
                pc = m_conf[ch][2:0];
                if (!addr[12] && pc == 3'd2) k &= {~p[1], ~p[0], ~p[2], ~p[3], ~f1(ch)};
                if (!addr[12] && pc == 3'd4) k &= {~p[2], ~p[3], ~p[0], 1'b1, ~f1(ch)};
                if (!addr[11] && pc == 3'd3) k &= {~f1(ch), ~p[3], ~p[2], ~p[0], ~p[1]};
                if (!addr[11] && pc == 3'd4) k &= {~p[1], 4'hF};
            end
        end
        return k;
    endfunction

    initial begin
        logic [7:0]  d;
        logic        o;
        logic [4:0]  k;
        logic [15:0] ra;
        logic [7:0]  za;
        logic [4:0]  kin;
        logic [7:0]  wdat;
        logic        af_pat [6];

        checks = 0;
        failures = 0;
        clk = 1'b0;
        rst = 1'b1;
        a = 16'hFFFF;
        iorq_n = 1'b1;
        rd_n = 1'b1;
        din = 8'h00;
        zxuno_addr = 8'h00;
        zxuno_regrd = 1'b0;
        zxuno_regwr = 1'b0;
        joy_in = '1;
        kbdcol_in = 5'h1F;
        vrt = 1'b1;
        model_reset();

        af_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        tbl[0] = '{"zx06",         16'hFFFF, 1'b1, 1'b1, 8'h06, 1'b1, 5'h1F, 8'h01, 1'b0, 5'h1F};
        tbl[1] = '{"zx07",         16'hFFFF, 1'b1, 1'b1, 8'h07, 1'b1, 5'h15, 8'h02, 1'b0, 5'h15};
        tbl[2] = '{"zx08_range",   16'hFFFF, 1'b1, 1'b1, 8'h08, 1'b1, 5'h1F, 8'hFF, 1'b1, 5'h1F};
        tbl[3] = '{"zx05_range",   16'hFFFF, 1'b1, 1'b1, 8'h05, 1'b1, 5'h1F, 8'hFF, 1'b1, 5'h1F};
        tbl[4] = '{"kemp_rst",     16'h001F, 1'b0, 1'b0, 8'h00, 1'b0, 5'h1F, 8'h00, 1'b0, 5'h1F};
        tbl[5] = '{"fuller_rst",   16'h007F, 1'b0, 1'b0, 8'h00, 1'b0, 5'h0E, 8'hFF, 1'b0, 5'h0E};
        tbl[6] = '{"kemp_noiorq",  16'h001F, 1'b1, 1'b0, 8'h00, 1'b0, 5'h1F, 8'hFF, 1'b1, 5'h1F};
        tbl[7] = '{"zx_over_kemp", 16'h001F, 1'b0, 1'b0, 8'h07, 1'b1, 5'h1F, 8'h02, 1'b0, 5'h1F};
        tbl[8] = '{"row_idle",     16'hEFFE, 1'b1, 1'b1, 8'h00, 1'b0, 5'h0A, 8'hFF, 1'b1, 5'h0A};
        tbl[9] = '{"kemp_nord",    16'h001F, 1'b0, 1'b1, 8'h00, 1'b0, 5'h1F, 8'hFF, 1'b1, 5'h1F};

        step(2);
        rst = 1'b0;
        step(2);

        // Reset-state decode table
        for (int i = 0; i < 10; i++) begin
            a = tbl[i].a;
            iorq_n = tbl[i].iorq_n;
            rd_n = tbl[i].rd_n;
            zxuno_addr = tbl[i].zaddr;
            zxuno_regrd = tbl[i].zrd;
            kbdcol_in = tbl[i].kin;
            #1;
            chk({tbl[i].name, "_dout"}, dout, tbl[i].edout);
            chk({tbl[i].name, "_oe"}, 8'(oe_n), 8'(tbl[i].eoe));
            chk({tbl[i].name, "_kbd"}, 8'(kbdcol_out), 8'(tbl[i].ekbd));
            step(1);
        end
        a = 16'hFFFF;
        iorq_n = 1'b1;
        rd_n = 1'b1;
        zxuno_regrd = 1'b0;
        kbdcol_in = 5'h1F;

        // Debounce: a 3-cycle glitch is rejected, a held press lands after DC+3
        joy_in[4] = 1'b0;
        step(3);
        joy_in[4] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            io_read(16'h001F, d, o, k);
            chk("glitch_rejected", d, 8'h00);
        end
        joy_in[4] = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step(1);
            io_read(16'h001F, d, o, k);
            chk($sformatf("debounce_c%0d", i), d, (i >= 7) ? 8'h10 : 8'h00);
        end

        // Two Kempston channels merged
        joy_in[4] = 1'b1;
        joy_in[5] = 1'b0;
        joy_in[0] = 1'b0;
        zx_write(8'h07, 8'h01);
        joy_in[W+6] = 1'b0;
        joy_in[W+3] = 1'b0;
        step(DC + 4);
        io_read(16'h001F, d, o, k);
        chk("kemp_merge", d, 8'h69);
        io_read(16'h007F, d, o, k);
        chk("fuller_none", d, 8'hFF);

        // Autofire with half-period 2
        joy_in = '1;
        joy_in[4] = 1'b0;
        step(DC + 4);
        zx_write(8'h06, 8'h29);
        io_read(16'h001F, d, o, k);
        chk("autofire_f0", d & 8'h10, af_pat[0] ? 8'h10 : 8'h00);
        for (int f = 1; f < 6; f++) begin
            frame();
            io_read(16'h001F, d, o, k);
            chk($sformatf("autofire_f%0d", f), d & 8'h10, af_pat[f] ? 8'h10 : 8'h00);
        end

        // Sinclair P1 and Cursor keyboard maps
        joy_in = '1;
        zx_write(8'h07, 8'h02);
        zx_write(8'h06, 8'h04);
        joy_in[W+3] = 1'b0;
        joy_in[1] = 1'b0;
        step(DC + 4);
        kbdcol_in = 5'h1F;
        io_read(16'hEFFE, d, o, k);
        chk("sp1_up", 8'(k), 8'h1D);
        kbdcol_in = 5'h17;
        io_read(16'hF7FE, d, o, k);
        chk("curs_left", 8'(k), 8'h07);
        kbdcol_in = 5'h1F;
        io_read(16'hEFFF, d, o, k);
        chk("row_a0_high", 8'(k), 8'h1F);
        io_read(16'h001F, d, o, k);
        chk("kemp_none", d, 8'h00);

        // Reset in the middle of autofire with a held button
        joy_in = '1;
        zx_write(8'h06, 8'h29);
        joy_in[4] = 1'b0;
        step(DC + 4);
        frame();
        @(posedge clk);
        #3;
        rst = 1'b1;
        io_read(16'h001F, d, o, k);
        chk("rst_kemp", d, 8'h00);
        chk("rst_kemp_oe", 8'(o), 8'h00);
        step(2);
        rst = 1'b0;
        model_reset();
        step(1);
        zx_read(8'h06, d, o);
        chk("rst_conf0", d, 8'h01);
        zx_read(8'h07, d, o);
        chk("rst_conf1", d, 8'h02);
        io_read(16'h001F, d, o, k);
        chk("rst_kemp_after", d, 8'h00);
        step(DC + 4);
        io_read(16'h001F, d, o, k);
        chk("rst_kemp_plain", d, 8'h10);

        // Randomised traffic against the reference model
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                za = 8'($urandom_range(4, 9));
                wdat = {2'b00, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        3'($urandom_range(0, 7))};
                zx_write(za, wdat);
            end
            joy_in = (NCHAN*W)'($urandom);
            step(1);
            for (int f = 0; f < int'($urandom_range(0, 3)); f++) frame();
            step(DC + 4);

            io_read(16'h001F, d, o, k);
            chk("rnd_kemp", d, exp_kemp());
            io_read(16'h007F, d, o, k);
            chk("rnd_fuller", d, exp_fuller());
            kin = 5'($urandom);
            kbdcol_in = kin;
            ra = {3'b111, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'h3FF,
                  1'($urandom_range(0, 3) == 0)};
            io_read(ra, d, o, k);
            chk($sformatf("rnd_kbd_%04h", ra), 8'(k), 8'(exp_kbd(ra, kin)));
            za = 8'($urandom_range(4, 9));
            zx_read(za, d, o);
            if (za >= BASE && za < BASE + 8'(NCHAN)) begin
                chk($sformatf("rnd_zx%02h", za), d, m_conf[za - BASE]);
                chk("rnd_zx_oe", 8'(o), 8'h00);
            end else begin
                chk($sformatf("rnd_zx%02h", za), d, 8'hFF);
                chk("rnd_zx_oe", 8'(o), 8'h01);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
